serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 68 ++++++
 tb/tb_serial_subtractor.sv | 115 +++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_res, r_diff, w_res_next;
   logic             r_br, r_borrow, w_d, w_br_next, w_last;
   logic [CW-1:0]    r_cnt;
   assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};
   assign w_last     = r_cnt == CW'(WIDTH - 1);
   assign busy       = r_state == RUN;
   assign done       = r_state == DONE;
   assign diff       = r_diff;
   assign borrow     = r_borrow;
   // next state: accept in IDLE, leave RUN after the last bit, DONE lasts one cycle
   always_comb begin
      w_next = IDLE;
      case (r_state)
         IDLE:    w_next = start ? RUN : IDLE;
         RUN:     w_next = w_last ? DONE : RUN;
         default: w_next = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   // datapath: capture operands, shift one bit per RUN cycle, publish result on the last bit
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_br     <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_a   <= a;
         r_b   <= b;
         r_br  <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= w_res_next;
         r_br  <= w_br_next;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_diff   <= w_res_next;
            r_borrow <= w_br_next;
         end
      end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against arithmetic a - b
module tb_serial_subtractor;
   localparam int WIDTH = 8;
   logic             clk = 1'b0, rst_n, start;
   logic [WIDTH-1:0] a, b, diff;
   logic             busy, done, borrow;
   int               n_vec = 0, n_err = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // one operation from IDLE; optional disturbance of start/a/b during RUN
   task automatic op(input logic [7:0] xa, input logic [7:0] xb, input bit disturb);
      logic [7:0] pd, ed;
      logic       pb;
      int         lat;
      bit         ok;
      pd = diff; pb = borrow; ok = 1'b1; lat = 0;
      ed = xa - xb;
      a = xa; b = xb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ok &= busy;
      for (int i = 1; i <= WIDTH + 4; i++) begin
         if (disturb && i == 3) begin a = ~xa; b = xa; start = 1'b1; end
         if (disturb && i == 4) start = 1'b0;
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
         ok &= busy && !done && diff === pd && borrow === pb;
      end
      chk("latency", lat, WIDTH);
      chk("run_stable", ok, 1);
      chk("diff", diff, ed);
      chk("borrow", borrow, xa < xb);
      chk("busy_with_done", busy, 0);
      @(posedge clk); #1;
      chk("done_single", done, 0);
   endtask

   initial begin
      int  dq[$];
      bit  ok;
      logic [7:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      op(8'h05, 8'h03, 1'b0);
      op(8'h03, 8'h05, 1'b0);
      op(8'h00, 8'h00, 1'b0);
      op(8'h00, 8'h01, 1'b0);
      a = 8'hFF; b = 8'h01; start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done) begin
            dq.push_back(i);
            chk("b2b_diff", diff, 8'hFE);
            chk("b2b_borrow", borrow, 0);
         end
      end
      start = 1'b0;
      chk("b2b_count", dq.size(), 2);
      chk("b2b_gap", dq.size() == 2 ? dq[1] - dq[0] : 0, WIDTH + 2);
      repeat (3) @(posedge clk);
      #1;
      op(8'h10, 8'h01, 1'b1);
      ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         ok &= !busy && !done;
      end
      chk("no_restart", ok, 1);
      a = 8'h3C; b = 8'h11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_diff", diff, 0);
      chk("midrst_borrow", borrow, 0);
      ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         ok &= !busy && !done;
      end
      chk("midrst_no_done", ok, 1);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      op(8'h80, 8'h7F, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         op(ra, rb, 1'b0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
